// File: rtl/mem_responder_if.sv
// Byte-wide controller bus plus TX (and optional RX) byte link of the memory responder.
// The RX link signals exist only when IO_RX_EN is defined.
interface mem_responder_if;
  logic [31:0] mc_to_mem_addr;
  logic        mc_to_mem_wr;
  logic [7:0]  mc_to_mem_dout;
  logic [7:0]  mem_to_mc_din;
  logic        io_buffer_full;
  logic [7:0]  io_tx_data;
  logic        io_tx_valid;
  logic        io_tx_ready;
  logic        io_overflow;
`ifdef IO_RX_EN
  logic [7:0]  io_rx_data;
  logic        io_rx_valid;
  logic        io_rx_ready;

  modport slave (
    input  mc_to_mem_addr, mc_to_mem_wr, mc_to_mem_dout, io_tx_ready, io_rx_data, io_rx_valid,
    output mem_to_mc_din, io_buffer_full, io_tx_data, io_tx_valid, io_overflow, io_rx_ready
  );
  modport master (
    output mc_to_mem_addr, mc_to_mem_wr, mc_to_mem_dout, io_tx_ready, io_rx_data, io_rx_valid,
    input  mem_to_mc_din, io_buffer_full, io_tx_data, io_tx_valid, io_overflow, io_rx_ready
  );
`else
  modport slave (
    input  mc_to_mem_addr, mc_to_mem_wr, mc_to_mem_dout, io_tx_ready,
    output mem_to_mc_din, io_buffer_full, io_tx_data, io_tx_valid, io_overflow
  );
  modport master (
    output mc_to_mem_addr, mc_to_mem_wr, mc_to_mem_dout, io_tx_ready,
    input  mem_to_mc_din, io_buffer_full, io_tx_data, io_tx_valid, io_overflow
  );
`endif
endinterface

// File: rtl/mem_responder.sv
// Memory responder: byte RAM with 1-cycle registered read, IO data register feeding a TX FIFO.
// Optional RX holding register enabled by defining IO_RX_EN.
//
// Handshakes: a byte moves on any link exactly on a rising clk_in edge where valid && ready
// are both high and rdy_in is high; valid never depends on ready.
module mem_responder #(
  parameter int          RAM_AW  = 17,
  parameter logic [31:0] IO_ADDR = 32'h30000,
  parameter int          FIFO_AW = 3
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  mem_responder_if.slave  bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C   = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] NEARFULL  = (FIFO_AW+1)'(DEPTH - 1);
  localparam logic [31:0]      IO_STAT   = IO_ADDR + 32'd4;

  logic [7:0] ram     [0:(1<<RAM_AW)-1];
  logic [7:0] fifo_mem[0:DEPTH-1];

  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [7:0]         din_q, din_d;
  logic               full_q, full_d;
  logic               overflow_q, overflow_d;

  logic [RAM_AW-1:0] ram_idx;
  logic              is_io, io_hit, ram_we, push_req, push, pop;
  logic              fifo_full, fifo_empty;
  logic [7:0]        io_rd_byte;

  assign ram_idx    = bus.mc_to_mem_addr[RAM_AW-1:0];
  assign is_io      = (bus.mc_to_mem_addr[17:16] == 2'b11);
  assign io_hit     = (bus.mc_to_mem_addr == IO_ADDR);
  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);

  // Reset also blocks RAM writes so an interrupted burst leaves only completed bytes.
  assign ram_we   = rdy_in && !rst_in && bus.mc_to_mem_wr && !is_io;
  assign push_req = rdy_in && bus.mc_to_mem_wr && io_hit;
  assign push     = push_req && !fifo_full;
  assign pop      = rdy_in && !fifo_empty && bus.io_tx_ready;

`ifdef IO_RX_EN
  logic       rx_held_q, rx_held_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_capture, rx_clear;

  assign rx_capture = rdy_in && bus.io_rx_valid && !rx_held_q;
  assign rx_clear   = rdy_in && !bus.mc_to_mem_wr && io_hit && rx_held_q;

  always_comb begin
    io_rd_byte = 8'h00;
    if (io_hit)
      io_rd_byte = rx_held_q ? rx_byte_q : 8'h00;
    else if (bus.mc_to_mem_addr == IO_STAT)
      io_rd_byte = {7'b0, rx_held_q};
  end

  always_comb begin
    rx_held_d = rx_held_q;
    rx_byte_d = rx_byte_q;
    if (rx_capture) begin
      rx_held_d = 1'b1;
      rx_byte_d = bus.io_rx_data;
    end else if (rx_clear) begin
      rx_held_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rx_held_q <= 1'b0;
      rx_byte_q <= 8'h00;
    end else begin
      rx_held_q <= rx_held_d;
      rx_byte_q <= rx_byte_d;
    end
  end

  assign bus.io_rx_ready = !rx_held_q;
`else
  assign io_rd_byte = (IO_STAT == IO_STAT) ? 8'h00 : 8'h00;
`endif

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push_req && fifo_full);
    din_d      = din_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Assert one entry early so a byte already in flight from the controller still fits.
    full_d = (count_d >= NEARFULL);
    if (rdy_in) din_d = is_io ? io_rd_byte : ram[ram_idx];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      din_q      <= 8'h00;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      din_q      <= din_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_idx] <= bus.mc_to_mem_dout;
  end

  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.mc_to_mem_dout;
  end

  assign bus.mem_to_mc_din  = din_q;
  assign bus.io_buffer_full = full_q;
  assign bus.io_tx_data     = fifo_mem[rd_ptr_q];
  assign bus.io_tx_valid    = !fifo_empty;
  assign bus.io_overflow    = overflow_q;
endmodule
